// File: rtl/gray_ptr_ctrl.sv
// gray_ptr_ctrl -- async-FIFO pointer controller for one clock domain.
//
// Holds an (ADDR_W+1)-bit binary pointer and its registered Gray image. It
// synchronises the other domain's Gray pointer and produces a registered full
// flag (IS_WRITE=1) or empty flag (IS_WRITE=0). One instance sits on each side
// of the FIFO.
//
// Parameters:
//   ADDR_W      RAM address width, depth = 2**ADDR_W (>= 2)
//   SYNC_STAGES remote-pointer synchroniser depth (>= 2)
//   IS_WRITE    1: write side (flag = full), 0: read side (flag = empty)
//
// Ports:
//   clk, rst_n  domain clock (rising edge), async active-low reset
//   inc_req     push/pop request
//   rmt_gray    Gray pointer from the other domain (asynchronous)
//   addr        RAM address, low ADDR_W bits of the binary pointer
//   ptr_gray    registered Gray pointer, sent to the other domain
//   flag        registered full/empty
//   inc_ack     inc_req & ~flag, the pointer advances on this edge
//   level       (only with GRAY_PTR_LEVEL_EN) registered fill level
//
// Optional feature macro: GRAY_PTR_LEVEL_EN adds the level output.
module gray_ptr_ctrl #(
  parameter int ADDR_W      = 3,
  parameter int SYNC_STAGES = 2,
  parameter bit IS_WRITE    = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc_req,
  input  logic [ADDR_W:0]   rmt_gray,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W:0]   ptr_gray,
  output logic              flag,
  output logic              inc_ack
`ifdef GRAY_PTR_LEVEL_EN
  ,
  output logic [ADDR_W:0]   level
`endif
);

  localparam int PW = ADDR_W + 1;

  logic [PW-1:0] bin_q, bin_d;
  logic [PW-1:0] gray_q, gray_d;
  logic          flag_q, flag_d;
  logic [SYNC_STAGES-1:0][PW-1:0] sync_q, sync_d;
  logic [PW-1:0] sync_gray;
  logic [PW-1:0] full_cmp;

  assign sync_gray = sync_q[SYNC_STAGES-1];

  always_comb begin
    inc_ack = inc_req & ~flag_q;
    bin_d   = bin_q + PW'(inc_ack);
    gray_d  = bin_d ^ (bin_d >> 1);
    // Full when the local pointer is exactly one lap ahead of the remote:
    // in Gray code that is the top two bits inverted, the rest equal.
    full_cmp = {~sync_gray[ADDR_W:ADDR_W-1], sync_gray[ADDR_W-2:0]};
    if (IS_WRITE) flag_d = (gray_d == full_cmp);
    else          flag_d = (gray_d == sync_gray);
  end

  // Plain flop chain: no logic between stages so only one bit of a Gray
  // transition can be captured mid-change.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = rmt_gray;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
      sync_q <= '0;
      // Read side starts empty; write side starts not-full.
      flag_q <= (IS_WRITE == 1'b0);
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      sync_q <= sync_d;
      flag_q <= flag_d;
    end
  end

  assign addr     = bin_q[ADDR_W-1:0];
  assign ptr_gray = gray_q;
  assign flag     = flag_q;

`ifdef GRAY_PTR_LEVEL_EN
  logic [PW-1:0] rbin;
  logic [PW-1:0] level_q, level_d;

  // Gray->binary: bit i is the XOR of all Gray bits at i and above.
  always_comb begin
    rbin = '0;
    for (int i = 0; i < PW; i++) rbin[i] = ^(sync_gray >> i);
    if (IS_WRITE) level_d = bin_d - rbin;
    else          level_d = rbin - bin_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_q <= '0;
    else        level_q <= level_d;
  end

  assign level = level_q;
`endif

endmodule

// File: tb/tb_gray_ptr_ctrl.sv
module tb_gray_ptr_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       w_inc = 1'b0, r_inc = 1'b0;
  logic [3:0] w_rmt = 4'h0, r_rmt = 4'h0;
  logic [2:0] w_addr, r_addr;
  logic [3:0] w_gray, r_gray;
  logic       w_flag, r_flag, w_ack, r_ack;
`ifdef GRAY_PTR_LEVEL_EN
  logic [3:0] w_level, r_level;
`endif

  int n_vec = 0;
  int n_err = 0;

  localparam logic [3:0] GSEQ [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                       4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  always #5 clk = ~clk;

  gray_ptr_ctrl #(.ADDR_W(3), .SYNC_STAGES(2), .IS_WRITE(1'b1)) dut_w (
    .clk(clk), .rst_n(rst_n), .inc_req(w_inc), .rmt_gray(w_rmt),
    .addr(w_addr), .ptr_gray(w_gray), .flag(w_flag), .inc_ack(w_ack)
`ifdef GRAY_PTR_LEVEL_EN
    , .level(w_level)
`endif
  );

  gray_ptr_ctrl #(.ADDR_W(3), .SYNC_STAGES(2), .IS_WRITE(1'b0)) dut_r (
    .clk(clk), .rst_n(rst_n), .inc_req(r_inc), .rmt_gray(r_rmt),
    .addr(r_addr), .ptr_gray(r_gray), .flag(r_flag), .inc_ack(r_ack)
`ifdef GRAY_PTR_LEVEL_EN
    , .level(r_level)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    w_inc = 1'b0; r_inc = 1'b0; w_rmt = 4'h0; r_rmt = 4'h0;
    rst_n = 1'b0;
    tick; tick;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    #2;
    w_inc = 1'b1; r_inc = 1'b1;
    rst_n = 1'b0;
    #1;
    n_vec++; if (w_addr !== 3'd0)  begin n_err++; $display("FAIL reset_w_addr got %h want 0", w_addr); end
    n_vec++; if (w_gray !== 4'h0)  begin n_err++; $display("FAIL reset_w_gray got %h want 0", w_gray); end
    n_vec++; if (w_flag !== 1'b0)  begin n_err++; $display("FAIL reset_w_flag got %b want 0", w_flag); end
    n_vec++; if (r_flag !== 1'b1)  begin n_err++; $display("FAIL reset_r_flag got %b want 1", r_flag); end
    n_vec++; if (r_ack !== 1'b0)   begin n_err++; $display("FAIL reset_r_ack got %b want 0", r_ack); end
    n_vec++; if (r_gray !== 4'h0)  begin n_err++; $display("FAIL reset_r_gray got %h want 0", r_gray); end
    do_reset;
  endtask

  task automatic test_fill;
    do_reset;
    w_inc = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_vec++; if (w_ack !== 1'b1) begin n_err++; $display("FAIL fill_ack[%0d] got %b want 1", i, w_ack); end
      tick;
      n_vec++; if (w_gray !== GSEQ[i+1]) begin n_err++; $display("FAIL fill_gray[%0d] got %h want %h", i, w_gray, GSEQ[i+1]); end
      n_vec++; if (w_flag !== (i == 7)) begin n_err++; $display("FAIL fill_flag[%0d] got %b want %b", i, w_flag, (i == 7)); end
    end
    // ninth request ignored
    n_vec++; if (w_ack !== 1'b0) begin n_err++; $display("FAIL full_ack got %b want 0", w_ack); end
    tick;
    n_vec++; if (w_gray !== 4'hC) begin n_err++; $display("FAIL full_hold_gray got %h want C", w_gray); end
    n_vec++; if (w_addr !== 3'd0) begin n_err++; $display("FAIL full_hold_addr got %h want 0", w_addr); end
    w_inc = 1'b0;
  endtask

  // Remote pops one entry while full: flag clears SYNC_STAGES+1 edges later.
  task automatic test_remote_release;
    w_rmt = 4'h1;
    for (int i = 1; i <= 3; i++) begin
      tick;
      n_vec++; if (w_flag !== (i < 3)) begin n_err++; $display("FAIL release_flag[%0d] got %b want %b", i, w_flag, (i < 3)); end
    end
    w_rmt = 4'h0;
  endtask

  task automatic test_wrap;
    logic [3:0] h0, h1;
    do_reset;
    h0 = 4'h0; h1 = 4'h0;
    w_inc = 1'b1;
    for (int i = 0; i < 16; i++) begin
      w_rmt = h0;
      #1;
      n_vec++; if (w_addr !== 3'(i % 8)) begin n_err++; $display("FAIL wrap_addr[%0d] got %h want %h", i, w_addr, i % 8); end
      n_vec++; if (w_ack !== 1'b1) begin n_err++; $display("FAIL wrap_ack[%0d] got %b want 1", i, w_ack); end
      tick;
      n_vec++; if (w_gray !== GSEQ[(i+1) % 16]) begin n_err++; $display("FAIL wrap_gray[%0d] got %h want %h", i, w_gray, GSEQ[(i+1) % 16]); end
      n_vec++; if (w_flag !== 1'b0) begin n_err++; $display("FAIL wrap_flag[%0d] got %b want 0", i, w_flag); end
      h0 = h1; h1 = w_gray;
    end
    w_inc = 1'b0;
  endtask

  task automatic test_read;
    do_reset;
    r_rmt = 4'h3;
    for (int i = 1; i <= 3; i++) begin
      tick;
      n_vec++; if (r_flag !== (i < 3)) begin n_err++; $display("FAIL rd_empty[%0d] got %b want %b", i, r_flag, (i < 3)); end
    end
    r_inc = 1'b1;
    #1;
    n_vec++; if (r_ack !== 1'b1) begin n_err++; $display("FAIL rd_ack0 got %b want 1", r_ack); end
    n_vec++; if (r_addr !== 3'd0) begin n_err++; $display("FAIL rd_addr0 got %h want 0", r_addr); end
    tick;
    n_vec++; if (r_addr !== 3'd1) begin n_err++; $display("FAIL rd_addr1 got %h want 1", r_addr); end
    n_vec++; if (r_flag !== 1'b0) begin n_err++; $display("FAIL rd_flag1 got %b want 0", r_flag); end
    n_vec++; if (r_ack !== 1'b1) begin n_err++; $display("FAIL rd_ack1 got %b want 1", r_ack); end
    tick;
    n_vec++; if (r_flag !== 1'b1) begin n_err++; $display("FAIL rd_flag2 got %b want 1", r_flag); end
    n_vec++; if (r_ack !== 1'b0) begin n_err++; $display("FAIL rd_ack2 got %b want 0", r_ack); end
    tick;
    n_vec++; if (r_addr !== 3'd2) begin n_err++; $display("FAIL rd_hold_addr got %h want 2", r_addr); end
    n_vec++; if (r_gray !== 4'h3) begin n_err++; $display("FAIL rd_hold_gray got %h want 3", r_gray); end
    r_inc = 1'b0;
  endtask

  task automatic test_async_reset;
    do_reset;
    w_inc = 1'b1;
    tick; tick; tick;
    n_vec++; if (w_gray !== 4'h2) begin n_err++; $display("FAIL ar_pre_gray got %h want 2", w_gray); end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++; if (w_gray !== 4'h0) begin n_err++; $display("FAIL ar_gray got %h want 0", w_gray); end
    n_vec++; if (w_addr !== 3'd0) begin n_err++; $display("FAIL ar_addr got %h want 0", w_addr); end
    n_vec++; if (r_flag !== 1'b1) begin n_err++; $display("FAIL ar_r_flag got %b want 1", r_flag); end
    tick;
    n_vec++; if (w_gray !== 4'h0) begin n_err++; $display("FAIL ar_held_gray got %h want 0", w_gray); end
    w_inc = 1'b0;
    rst_n = 1'b1;
    tick;
    n_vec++; if (w_addr !== 3'd0) begin n_err++; $display("FAIL ar_release_addr got %h want 0", w_addr); end
    w_inc = 1'b1;
    tick;
    n_vec++; if (w_gray !== 4'h1) begin n_err++; $display("FAIL ar_restart_gray got %h want 1", w_gray); end
    w_inc = 1'b0;
  endtask

`ifdef GRAY_PTR_LEVEL_EN
  task automatic test_level;
    do_reset;
    n_vec++; if (w_level !== 4'd0) begin n_err++; $display("FAIL lvl_reset got %0d want 0", w_level); end
    w_inc = 1'b1;
    repeat (5) tick;
    w_inc = 1'b0;
    n_vec++; if (w_level !== 4'd5) begin n_err++; $display("FAIL lvl_push5 got %0d want 5", w_level); end
    w_rmt = 4'h3;
    for (int i = 1; i <= 3; i++) begin
      tick;
      n_vec++; if (w_level !== ((i < 3) ? 4'd5 : 4'd3)) begin n_err++; $display("FAIL lvl_remote[%0d] got %0d want %0d", i, w_level, (i < 3) ? 5 : 3); end
    end
  endtask
`endif

  initial begin
    test_reset;
    test_fill;
    test_remote_release;
    test_wrap;
    test_read;
    test_async_reset;
`ifdef GRAY_PTR_LEVEL_EN
    test_level;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
